// File: rtl/vec_serializer.sv
// rtl/vec_serializer.sv - replays one wide score vector as a narrow word stream and reports the argmax index
module vec_serializer #(
  parameter int INPUT_WIDTH = 32,
  parameter int INPUT_NUM   = 10,
  parameter int IDX_W       = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [INPUT_WIDTH*INPUT_NUM-1:0] data_in,
  input  logic                             data_in_vaild,
  output logic                             data_in_ready,
  output logic [INPUT_WIDTH-1:0]           data_out,
  output logic                             data_out_vaild,
  input  logic                             data_out_ready,
  output logic                             data_out_last,
  output logic [IDX_W-1:0]                 class_out,
  output logic                             class_out_vaild
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_NUM - 1);

  logic [0:0]                    state;
  logic [INPUT_WIDTH-1:0]        buf_q [INPUT_NUM];
  logic [IDX_W-1:0]              idx;
  logic signed [INPUT_WIDTH-1:0] max_val;
  logic [IDX_W-1:0]              max_idx;

  logic                          sending;
  logic                          is_last;
  logic                          beat_accept;
  logic                          capture;
  logic                          greater;
  logic signed [INPUT_WIDTH-1:0] cur;
  logic [IDX_W-1:0]              next_max_idx;

  // Stream-side decode: current element, last flag, handshakes and running argmax candidate
  always_comb begin
    sending      = (state == SEND);
    cur          = buf_q[idx];
    is_last      = sending && (idx == LAST_IDX);
    beat_accept  = sending && data_out_ready;
    // Ready is offered when idle, or when the final beat is leaving this cycle so a
    // new vector can follow with no bubble; held low during reset.
    data_in_ready = !rst && (!sending || (is_last && data_out_ready));
    capture      = data_in_vaild && data_in_ready;
    // Strictly greater keeps the lower index on ties; element 0 equals max_val, so it never wins.
    greater      = (cur > max_val);
    next_max_idx = greater ? idx : max_idx;
    data_out       = sending ? cur : '0;
    data_out_vaild = sending;
    data_out_last  = is_last;
  end

  // State, buffer, beat counter, running max and class report
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      idx             <= '0;
      max_val         <= '0;
      max_idx         <= '0;
      class_out       <= '0;
      class_out_vaild <= 1'b0;
      for (int k = 0; k < INPUT_NUM; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      class_out_vaild <= 1'b0;

      if (beat_accept) begin
        if (greater) begin
          max_val <= cur;
          max_idx <= idx;
        end
        if (is_last) begin
          class_out       <= next_max_idx;
          class_out_vaild <= 1'b1;
          state           <= IDLE;
        end else begin
          idx <= idx + 1'b1;
        end
      end

      // A capture on the last-beat edge overrides the return to IDLE above.
      if (capture) begin
        for (int k = 0; k < INPUT_NUM; k++) begin
          buf_q[k] <= data_in[k*INPUT_WIDTH +: INPUT_WIDTH];
        end
        idx     <= '0;
        max_val <= $signed(data_in[INPUT_WIDTH-1:0]);
        max_idx <= '0;
        state   <= SEND;
      end
    end
  end

endmodule

// File: doc/vec_serializer.md
# vec_serializer

Output-side companion to the generated network top. It accepts one wide result vector (INPUT_NUM signed words, for example the 10 × 32-bit classifier scores) over a valid/ready handshake and replays it as a narrow stream, one word per beat. It flags the final beat and, one cycle after that beat, reports the index of the largest score. It sits between the last `fc` layer output and a narrow sink (UART/DMA/host FIFO).

## Interface
Parameters:
- INPUT_WIDTH, 32, width of one element, signed two's complement
- INPUT_NUM, 10, elements per input vector; legal range ≥1
- IDX_W, $clog2(INPUT_NUM) (min 1), width of beat counter and class index

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- data_in  input  INPUT_WIDTH*INPUT_NUM  vector; element k at bits [k*INPUT_WIDTH +: INPUT_WIDTH]
- data_in_vaild  input  1  vector valid
- data_in_ready  output  1  block can capture a vector
- data_out  output  INPUT_WIDTH  current element
- data_out_vaild  output  1  data_out valid
- data_out_ready  input  1  sink accepts data_out
- data_out_last  output  1  current beat is element INPUT_NUM-1
- class_out  output  IDX_W  index of maximum element of last completed vector
- class_out_vaild  output  1  one-cycle pulse when class_out updates

## Operation
- Two states: IDLE, SEND. Reset forces IDLE.
- IDLE behaviour:
  - data_in_ready=1, data_out_vaild=0.
  - On data_in_vaild: capture whole vector into a buffer, idx←0, max←element 0, max_idx←0, go to SEND.
- SEND behaviour:
  - data_out=buf[idx], data_out_vaild=1, data_out_last=(idx==INPUT_NUM-1).
- Beat accept (data_out_vaild && data_out_ready):
  - Compare buf[idx] signed against max; if strictly greater, max←buf[idx], max_idx←idx. Ties keep the lower index. Element 0 needs no compare.
  - Not last: idx←idx+1.
  - Last: class_out←final max_idx (including the compare of the last element) and class_out_vaild pulses next cycle.
    - If data_in_vaild is also high that cycle, capture the new vector and restart SEND at idx 0.
    - Otherwise go to IDLE.
- data_in_ready = IDLE || (SEND && data_out_last && data_out_ready); combinational, no data_in_vaild dependency.
- data_out, data_out_last are stable while data_out_vaild && !data_out_ready.
- Buffer is not overwritten outside a capture handshake.
- INPUT_NUM=1: first beat is last; class_out=0.

## Timing
- Reset values while rst=1 and the cycle after release:
  - data_in_ready=0 during rst, 1 in the first cycle after release
  - data_out=0, data_out_vaild=0, data_out_last=0
  - class_out=0, class_out_vaild=0, buffer=0
- Vector captured at edge T → element 0 valid in cycle T+1. With continuous ready, element k is presented in cycle T+1+k.
- Last beat accepted at edge L → class_out_vaild=1 during cycle L+1 only. class_out holds until the next update.
- Back-to-back: a vector captured on the last-beat edge yields element 0 in the following cycle. Sustained throughput is INPUT_NUM beats per vector, no bubble.
- Backpressure stalls idx and compare state indefinitely. No timeout.
- rst mid-SEND: abort immediately and return to IDLE. No class_out_vaild pulse for the aborted vector. Partial max state is discarded.

## Test plan
- Reset check: hold rst 3 cycles with data_in_vaild=1 → data_in_ready=0, all outputs 0; after release data_in_ready=1 and nothing is captured until the first ready cycle.
- Basic stream: INPUT_NUM=10, elements {5,-3,12,7,0,1,12,-8,2,9}, data_out_ready=1 → beats 5,-3,12,…,9 in cycles T+1..T+10; data_out_last only on beat 9; class_out=2 (tie with index 6 keeps 2); class_out_vaild pulses at T+11.
- Negative scores: all elements −100 except element 8 = −1 → class_out=8 (signed compare, not unsigned).
- Backpressure: toggle data_out_ready randomly 50% → data_out is stable across stalls, no beat is dropped or duplicated, data_in_ready stays 0 until the last beat is accepted.
- Back-to-back: two vectors, the second presented with data_in_vaild during the first's last beat → 20 consecutive beats with no gap; two class_out_vaild pulses exactly 10 cycles apart.
- Reset mid-stream: assert rst after beat 4 → data_out_vaild=0 the next cycle, no class_out_vaild; a subsequent vector streams correctly from element 0.
